// File: rtl/br_pkg.sv
// Shared types and constants for the branch redirect unit.
package br_pkg;

    // Redirect controller states.
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    // Conditional-branch funct3 encodings.
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/br_cond_dec.sv
// Branch condition decoder: maps funct3 and comparator flags to a taken
// condition, and tells the comparator whether to compare signed.
module br_cond_dec
    import br_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    output logic       cond,
    output logic       br_un
);

    // Decode funct3; the reserved encodings 010/011 never take.
    always_comb begin
        cond  = 1'b0;
        br_un = 1'b0;
        case (funct3)
            BEQ:  cond = equal;
            BNE:  cond = !equal;
            BLT:  begin cond = less;  br_un = 1'b1; end
            BGE:  begin cond = !less; br_un = 1'b1; end
            BLTU: cond = less;
            BGEU: cond = !less;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_redirect.sv
// Fetch PC generator with branch/jump redirect, post-redirect flush window,
// sticky misaligned-target trap and a saturating redirect counter.
module br_redirect
    import br_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_is_branch,
    input  logic        i_is_jump,
    input  logic [2:0]  i_funct3,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    input  logic [31:0] i_target,
    input  logic        i_stall,
    output logic        o_br_un,
    output logic [31:0] o_pc,
    output logic        o_taken,
    output logic        o_flush,
    output logic        o_trap,
    output logic [15:0] o_taken_cnt
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      state;
    logic [2:0]  flush_cnt;
    logic [31:0] pc;
    logic        taken;
    logic [15:0] taken_cnt;
    logic        cond;
    logic        take;
    logic [31:0] pc_seq;

    br_cond_dec u_cond_dec (
        .funct3 (i_funct3),
        .less   (i_br_less),
        .equal  (i_br_equal),
        .cond   (cond),
        .br_un  (o_br_un)
    );

    // Jumps are unconditional, so they win over any branch condition.
    assign take   = i_valid && (state == S_RUN) && (i_is_jump || (i_is_branch && cond));
    // Sequential fetch advance; a stall simply holds the PC.
    assign pc_seq = i_stall ? pc : (pc + 32'd4);

    // Redirect FSM, PC register, flush timer and redirect counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_RUN;
            flush_cnt <= 3'd0;
            pc        <= RESET_PC;
            taken     <= 1'b0;
            taken_cnt <= 16'd0;
        end else begin
            taken <= 1'b0;
            case (state)
                S_RUN: begin
                    if (take) begin
                        if (i_target[1:0] == 2'b00) begin
                            pc        <= i_target;
                            taken     <= 1'b1;
                            flush_cnt <= FLUSH_INIT;
                            state     <= S_FLUSH;
                            if (taken_cnt != 16'hFFFF)
                                taken_cnt <= taken_cnt + 16'd1;
                        end else begin
                            state <= S_TRAP;
                        end
                    end else begin
                        pc <= pc_seq;
                    end
                end
                S_FLUSH: begin
                    pc        <= pc_seq;
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1)
                        state <= S_RUN;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign o_pc        = pc;
    assign o_taken     = taken;
    assign o_flush     = (state == S_FLUSH);
    assign o_trap      = (state == S_TRAP);
    assign o_taken_cnt = taken_cnt;

endmodule

// File: tb/tb_br_redirect.sv
// Bench for br_redirect: directed scenarios with literal expectations plus
// randomized traffic, all compared against a behavioural model.
module tb_br_redirect;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          FC     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, is_branch, is_jump, less, equal, stall;
    logic [2:0]  funct3;
    logic [31:0] target;
    logic        br_un, taken, flush, trap;
    logic [31:0] pc;
    logic [15:0] taken_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: mode 0 = running, 2 = trapped; flush is
    // simply "flush cycles still owed".
    logic [31:0] m_pc;
    int          m_mode;
    int          m_left;
    logic        m_taken;
    logic [15:0] m_cnt;
    logic        cnt_pend = 1'b0;

    always #5 clk = ~clk;

    br_redirect #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (valid),
        .i_is_branch (is_branch),
        .i_is_jump   (is_jump),
        .i_funct3    (funct3),
        .i_br_less   (less),
        .i_br_equal  (equal),
        .i_target    (target),
        .i_stall     (stall),
        .o_br_un     (br_un),
        .o_pc        (pc),
        .o_taken     (taken),
        .o_flush     (flush),
        .o_trap      (trap),
        .o_taken_cnt (taken_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_of(input logic [2:0] f3, input logic lt, input logic eq);
        case (f3)
            3'b000:          return eq;
            3'b001:          return !eq;
            3'b100, 3'b110:  return lt;
            3'b101, 3'b111:  return !lt;
            default:         return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_pc = RST_PC; m_mode = 0; m_left = 0; m_taken = 1'b0; m_cnt = 16'd0;
        end else begin
            if (cnt_pend) m_cnt = 16'hFFFE;
            m_taken = 1'b0;
            if (m_mode == 2) begin
                // frozen until reset
            end else if (m_left > 0) begin
                if (!stall) m_pc = m_pc + 32'd4;
                m_left--;
            end else if (valid && (is_jump || (is_branch && cond_of(funct3, less, equal)))) begin
                if (target[1:0] == 2'b00) begin
                    m_pc = target; m_taken = 1'b1; m_left = FC;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end else begin
                    m_mode = 2;
                end
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        check("pc",      pc,        m_pc);
        check("taken",   32'(taken), 32'(m_taken));
        check("flush",   32'(flush), 32'(m_left > 0));
        check("trap",    32'(trap),  32'(m_mode == 2));
        check("cnt",     32'(taken_cnt), 32'(m_cnt));
        check("br_un",   32'(br_un), 32'(funct3 == 3'b100 || funct3 == 3'b101));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic b, input logic j, input logic [2:0] f3,
                         input logic lt, input logic eq, input logic [31:0] tgt, input logic st);
        valid = v; is_branch = b; is_jump = j; funct3 = f3;
        less = lt; equal = eq; target = tgt; stall = st;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_pc = 32'h0; m_mode = 0; m_left = 0; m_taken = 1'b0; m_cnt = 16'd0;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_pc",    pc,               32'h0);
        check("rst_flush", 32'(flush),       32'd0);
        check("rst_trap",  32'(trap),        32'd0);
        check("rst_cnt",   32'(taken_cnt),   32'd0);

        // Free-running fetch
        rst = 1'b0;
        cycle(); check("seq_pc4",  pc, 32'h4);
        cycle(); check("seq_pc8",  pc, 32'h8);
        cycle(); check("seq_pc12", pc, 32'hC);
        check("seq_flush", 32'(flush), 32'd0);

        // BLT taken to 0x100
        drive(1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 32'h100, 1'b0);
        #1 check("blt_br_un", 32'(br_un), 32'd1);
        cycle();
        check("blt_pc",    pc,           32'h100);
        check("blt_taken", 32'(taken),   32'd1);
        check("blt_fl1",   32'(flush),   32'd1);
        idle();
        cycle();
        check("blt_fl2",   32'(flush),   32'd1);
        check("blt_tk2",   32'(taken),   32'd0);
        cycle();
        check("blt_fl3",   32'(flush),   32'd0);
        check("blt_pc3",   pc,           32'h108);
        check("blt_cnt",   32'(taken_cnt), 32'd1);

        // BGEU with less=1 and BNE with equal=1: both fall through
        drive(1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 32'h400, 1'b0);
        #1 check("bgeu_br_un", 32'(br_un), 32'd0);
        cycle();
        check("bgeu_pc", pc, 32'h10C);
        drive(1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 32'h400, 1'b0);
        cycle();
        check("bne_pc", pc, 32'h110);

        // Jump under stall, then a branch offered during the flush window
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h200, 1'b1);
        cycle();
        check("jmp_pc",  pc, 32'h200);
        check("jmp_cnt", 32'(taken_cnt), 32'd2);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h300, 1'b0);
        cycle();
        check("fl_br_pc1", pc, 32'h204);
        cycle();
        check("fl_br_pc2", pc, 32'h208);
        check("fl_br_cnt", 32'(taken_cnt), 32'd2);
        idle();

        // Counter saturation and PC wrap
        force dut.taken_cnt = 16'hFFFE;
        cnt_pend = 1'b1;
        #1 release dut.taken_cnt;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b0);
        cycle();
        cnt_pend = 1'b0;
        check("sat_cnt1", 32'(taken_cnt), 32'hFFFF);
        idle();
        cycle();
        check("wrap_fc", pc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_0", pc, 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h40 << k, 1'b0);
            cycle();
            idle();
            cycle();
            cycle();
        end
        check("sat_cnt3", 32'(taken_cnt), 32'hFFFF);
        check("sat_pc",   pc, 32'h88);

        // Misaligned jump traps and freezes the PC
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h202, 1'b0);
        cycle();
        check("trap_set", 32'(trap), 32'd1);
        check("trap_tk",  32'(taken), 32'd0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'($urandom), 1'b1, 3'($urandom), 1'($urandom), 1'($urandom),
                  32'h500, 1'($urandom));
            cycle();
            check("trap_pc", pc, 32'h88);
        end
        rst = 1'b1;
        cycle();
        check("trap_rst_pc",   pc,         RST_PC);
        check("trap_rst_trap", 32'(trap),  32'd0);
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom),
                  {$urandom_range(0, 32'h3FFF_FFFF) << 2} |
                      (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0),
                  ($urandom_range(0, 3) == 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_redirect.md
BR_REDIRECT -- requirements
Module: br_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7, is the number of cycles o_flush is asserted after a redirect.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports: i_clk  in  1  clock, rising-edge.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_valid  in  1  EX-stage instruction valid.
REQ-006 i_is_branch  in  1  EX instruction is a conditional branch.
REQ-007 i_is_jump  in  1  EX instruction is JAL/JALR.
REQ-008 i_funct3  in  3  branch funct3.
REQ-009 i_br_less, i_br_equal  in  1 each  comparator results for the current EX operands.
REQ-010 i_target  in  32  branch/jump target address.
REQ-011 i_stall  in  1  fetch stall request.
REQ-012 o_br_un  out  1  comparator mode to the comparator: 1 = signed, 0 = unsigned.
REQ-013 o_pc  out  32  fetch PC.
REQ-014 o_taken  out  1  registered one-cycle pulse, redirect performed.
REQ-015 o_flush  out  1  squash the IF/ID instructions.
REQ-016 o_trap  out  1  sticky misaligned-target trap.
REQ-017 o_taken_cnt  out  16  count of redirects, saturating.

Function
REQ-018 o_br_un SHALL be combinational: 1 for funct3 100/101, 0 otherwise.
REQ-019 The condition SHALL decode as follows: 000 = equal; 001 = !equal; 100/110 = less; 101/111 = !less; 010/011 = never taken.
REQ-020 take SHALL be i_valid & state==S_RUN & (i_is_jump | (i_is_branch & cond)); jump wins when both flags are set.
REQ-021 The FSM SHALL have states S_RUN, S_FLUSH, S_TRAP; the reset state is S_RUN.
REQ-022 S_RUN, take with i_target[1:0]==0: next o_pc=i_target, o_taken=1, counter=FLUSH_CYCLES, go to S_FLUSH; redirect overrides i_stall.
REQ-023 S_RUN, take with i_target[1:0]!=0: go to S_TRAP with o_pc held, no redirect, o_taken=0, count unchanged.
REQ-024 S_RUN, no take: o_pc += 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) unless i_stall, which holds o_pc.
REQ-025 S_FLUSH: o_flush=1; i_valid/branch/jump inputs are ignored; o_pc advances per REQ-024 stall rule; the counter decrements each cycle; return to S_RUN after FLUSH_CYCLES cycles.
REQ-026 S_TRAP: o_trap=1, o_pc frozen, all inputs ignored until reset.
REQ-027 o_flush SHALL be a Moore output of state, with no combinational path from inputs.
REQ-028 Redirect latency SHALL be one clock: the target appears on o_pc at the edge after the taken EX cycle.
REQ-029 o_taken_cnt SHALL increment on each redirect and saturate at 16'hFFFF.

Reset
REQ-030 On i_reset at the clock edge: o_pc=RESET_PC, state=S_RUN, o_taken=0, o_flush=0, o_trap=0, o_taken_cnt=0, and the flush counter cleared.
REQ-031 Reset SHALL take priority over every event, including mid-flush and in S_TRAP; no asynchronous reset path.

Structure
REQ-032 Package br_pkg SHALL hold the state enum and the funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
REQ-033 Combinational sub-module br_cond_dec (funct3, less, equal -> cond, br_un) SHALL be instantiated once; all sequential logic stays in br_redirect.

Verification
REQ-034 Reset, then 3 unstalled cycles -> o_pc = 0, 4, 8, 12; o_flush=0.
REQ-035 BLT, funct3=100, less=1, target=32'h100 -> o_br_un=1; next cycle o_pc=0x100 and o_taken=1; o_flush=1 for exactly 2 cycles; count=1.
REQ-036 BGEU, less=1 -> not taken, o_br_un=0, o_pc+4; BNE with equal=1 -> not taken.
REQ-037 Jump to 0x200 with i_stall=1 -> o_pc=0x200; a branch presented during flush is ignored.
REQ-038 Jump to 0x202 -> o_trap=1, o_pc frozen for 10 cycles; reset -> o_pc=RESET_PC, o_trap=0.
REQ-039 Force the count to 0xFFFE and perform 3 redirects -> o_taken_cnt=0xFFFF; o_pc at 0xFFFF_FFFC wraps to 0.
